// File: rtl/mt9d111_capture.sv
// MT9D111 DVP capture: 8-bit VSYNC/HREF/D stream -> RGB565 pixels with counters and strobes.
// Optional colour-bar test pattern when MT9D111_CAPTURE_TESTPAT_EN is defined (adds tp_sel).
module mt9d111_capture #(
    parameter int H_WIDTH     = 800,
    parameter int V_WIDTH     = 600,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        MT9D111_CLK,
    input  logic        sys_rst,
    input  logic        MT9D111_VSYNC,
    input  logic        MT9D111_HREF,
    input  logic [7:0]  MT9D111_D,
`ifdef MT9D111_CAPTURE_TESTPAT_EN
    input  logic        tp_sel,
`endif
    output logic [15:0] MT9D111_FrameData,
    output logic        MT9D111_FrameDataEn,
    output logic [10:0] MT9D111_FrameHCnt,
    output logic [10:0] MT9D111_FrameVCnt,
    output logic        MT9D111_FrameNewEn,
    output logic        line_err,
    output logic        frame_short
);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        SYNC    = 2'd1,
        SKIP    = 2'd2,
        ACTIVE  = 2'd3
    } state_t;

    localparam logic [10:0] H_MAX   = 11'(H_WIDTH);
    localparam logic [10:0] V_MAX   = 11'(V_WIDTH);
    localparam logic [10:0] CNT_SAT = 11'd2047;
    localparam logic [3:0]  SKIP_INIT = 4'(SKIP_FRAMES);

    state_t      state;
    logic        vs_r, vs_rr, href_r, href_rr;
    logic [7:0]  d_r;
    logic [3:0]  skip_cnt;
    logic        phase;
    logic [7:0]  hi_byte;
    logic [10:0] h_cnt, v_cnt;
    logic        line_seen;

    logic        vs_rise, vs_fall, href_fall, line_end;
    logic [10:0] v_after;
    logic [15:0] pix_data;

    // A line also ends when VSYNC rises while HREF is still high.
    always_comb begin
        vs_rise   = vs_r & ~vs_rr;
        vs_fall   = ~vs_r & vs_rr;
        href_fall = ~href_r & href_rr;
        line_end  = href_fall | (vs_rise & href_r);
        v_after   = v_cnt;
        if (line_end && (line_seen || href_r) && (v_cnt != CNT_SAT))
            v_after = v_cnt + 11'd1;
    end

`ifdef MT9D111_CAPTURE_TESTPAT_EN
    localparam logic [10:0] Q1 = 11'(H_WIDTH / 4);
    localparam logic [10:0] Q2 = 11'(H_WIDTH / 2);
    localparam logic [10:0] Q3 = 11'((3 * H_WIDTH) / 4);

    // h_cnt equals FrameHCnt-1 for the pixel being emitted.
    always_comb begin
        pix_data = {hi_byte, d_r};
        if (tp_sel) begin
            if (h_cnt < Q1)
                pix_data = 16'hF800;
            else if (h_cnt < Q2)
                pix_data = 16'h07E0;
            else if (h_cnt < Q3)
                pix_data = 16'h001F;
            else
                pix_data = 16'hF81F;
        end
    end
`else
    assign pix_data = {hi_byte, d_r};
`endif

    always_ff @(posedge MT9D111_CLK) begin
        if (sys_rst) begin
            state               <= WAIT_VS;
            vs_r                <= 1'b0;
            vs_rr               <= 1'b0;
            href_r              <= 1'b0;
            href_rr             <= 1'b0;
            d_r                 <= 8'd0;
            skip_cnt            <= SKIP_INIT;
            phase               <= 1'b0;
            hi_byte             <= 8'd0;
            h_cnt               <= 11'd0;
            v_cnt               <= 11'd0;
            line_seen           <= 1'b0;
            MT9D111_FrameData   <= 16'd0;
            MT9D111_FrameDataEn <= 1'b0;
            MT9D111_FrameHCnt   <= 11'd0;
            MT9D111_FrameVCnt   <= 11'd0;
            MT9D111_FrameNewEn  <= 1'b0;
            line_err            <= 1'b0;
            frame_short         <= 1'b0;
        end else begin
            vs_r    <= MT9D111_VSYNC;
            vs_rr   <= vs_r;
            href_r  <= MT9D111_HREF;
            href_rr <= href_r;
            d_r     <= MT9D111_D;

            MT9D111_FrameDataEn <= 1'b0;
            MT9D111_FrameNewEn  <= 1'b0;
            line_err            <= 1'b0;
            frame_short         <= 1'b0;

            case (state)
                WAIT_VS: begin
                    if (vs_r)
                        state <= SYNC;
                end
                SYNC: begin
                    if (vs_fall) begin
                        if (skip_cnt != 4'd0) begin
                            skip_cnt <= skip_cnt - 4'd1;
                            state    <= SKIP;
                        end else begin
                            state              <= ACTIVE;
                            MT9D111_FrameNewEn <= 1'b1;
                            v_cnt              <= 11'd0;
                            h_cnt              <= 11'd0;
                            phase              <= 1'b0;
                            line_seen          <= 1'b0;
                        end
                    end
                end
                SKIP: begin
                    if (vs_rise)
                        state <= SYNC;
                end
                ACTIVE: begin
                    if (line_end) begin
                        line_err  <= phase;
                        v_cnt     <= v_after;
                        h_cnt     <= 11'd0;
                        phase     <= 1'b0;
                        line_seen <= 1'b0;
                    end else if (href_r) begin
                        line_seen <= 1'b1;
                        phase     <= ~phase;
                        if (!phase) begin
                            hi_byte <= d_r;
                        end else begin
                            if ((h_cnt < H_MAX) && (v_cnt < V_MAX)) begin
                                MT9D111_FrameDataEn <= 1'b1;
                                MT9D111_FrameData   <= pix_data;
                                MT9D111_FrameHCnt   <= h_cnt + 11'd1;
                                MT9D111_FrameVCnt   <= v_cnt;
                            end
                            if (h_cnt != CNT_SAT)
                                h_cnt <= h_cnt + 11'd1;
                        end
                    end
                    if (vs_rise) begin
                        frame_short <= (v_after < V_MAX);
                        state       <= SYNC;
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_mt9d111_capture.sv
// Scoreboard bench for mt9d111_capture (H_WIDTH=4, V_WIDTH=3, SKIP_FRAMES=2).
module tb_mt9d111_capture;

    localparam int HW = 4;
    localparam int VW = 3;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        vs = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  d = 8'd0;
    logic [15:0] frame_data;
    logic        frame_en;
    logic [10:0] hcnt, vcnt;
    logic        frame_new, line_err, frame_short;

    always #5 clk = ~clk;

    mt9d111_capture #(
        .H_WIDTH(HW),
        .V_WIDTH(VW),
        .SKIP_FRAMES(2)
    ) dut (
        .MT9D111_CLK(clk),
        .sys_rst(sys_rst),
        .MT9D111_VSYNC(vs),
        .MT9D111_HREF(href),
        .MT9D111_D(d),
        .MT9D111_FrameData(frame_data),
        .MT9D111_FrameDataEn(frame_en),
        .MT9D111_FrameHCnt(hcnt),
        .MT9D111_FrameVCnt(vcnt),
        .MT9D111_FrameNewEn(frame_new),
        .line_err(line_err),
        .frame_short(frame_short)
    );

    logic [37:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int new_seen = 0, lerr_seen = 0, fshort_seen = 0;
    int new_exp = 0, lerr_exp = 0, fshort_exp = 0;
    logic [7:0] next_byte = 8'h12;
    logic [7:0] hi = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expected pixel per strobe and counts pulses.
    always @(negedge clk) begin
        if (frame_new) new_seen++;
        if (line_err) lerr_seen++;
        if (frame_short) fshort_seen++;
        if (frame_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got data=%h h=%0d v=%0d expected no strobe",
                         frame_data, hcnt, vcnt);
            end else begin
                check("pixel", {26'd0, frame_data, hcnt, vcnt}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic begin_frame(input bit capture);
        @(negedge clk);
        vs = 1'b1;
        href = 1'b0;
        repeat (3) @(negedge clk);
        vs = 1'b0;
        if (capture) new_exp++;
        next_byte = 8'h12;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_line(input int nbytes, input bit capture, input int line_idx);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            href = 1'b1;
            d = next_byte;
            if ((i % 2) == 0)
                hi = next_byte;
            else if (capture && ((i / 2) < HW) && (line_idx < VW))
                exp_q.push_back({hi, next_byte, 11'(i / 2 + 1), 11'(line_idx)});
            next_byte = next_byte + 8'h22;
        end
        @(negedge clk);
        href = 1'b0;
        d = 8'd0;
        if (capture && (nbytes % 2 == 1)) lerr_exp++;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input int lines, input int nbytes, input bit capture);
        begin_frame(capture);
        for (int l = 0; l < lines; l++)
            send_line(nbytes, capture, l);
        if (capture && (lines < VW)) fshort_exp++;
    endtask

    // Raise VSYNC (ends any active frame) and compare the pulse tallies.
    task automatic settle(input string tag);
        @(negedge clk);
        vs = 1'b1;
        href = 1'b0;
        repeat (8) @(negedge clk);
        check({tag, "_frame_new"}, 64'(new_seen), 64'(new_exp));
        check({tag, "_line_err"}, 64'(lerr_seen), 64'(lerr_exp));
        check({tag, "_frame_short"}, 64'(fshort_seen), 64'(fshort_exp));
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        check("reset_outputs", {22'd0, frame_data, frame_en, hcnt, vcnt, frame_new, line_err, frame_short},
              64'd0);

        // Two start-up frames skipped, third captured.
        send_frame(3, 8, 1'b0);
        send_frame(3, 8, 1'b0);
        send_frame(3, 8, 1'b1);
        settle("skip3");
        check("hold_last_pixel", {26'd0, frame_data, hcnt, vcnt}, {26'd0, 16'hFE20, 11'd4, 11'd2});

        // Odd-length line: 4 pixels, one line_err, next line VCnt=1.
        begin_frame(1'b1);
        send_line(9, 1'b1, 0);
        send_line(8, 1'b1, 1);
        send_line(8, 1'b1, 2);
        settle("odd_line");

        // Oversized frame clipped to 4x3.
        send_frame(4, 12, 1'b1);
        settle("clip");

        // Short frame then a full frame restarting at VCnt=0.
        send_frame(2, 8, 1'b1);
        settle("short");
        send_frame(3, 8, 1'b1);
        settle("after_short");

        // Reset in the middle of a line cancels the in-flight pixel.
        begin_frame(1'b1);
        send_line(8, 1'b1, 0);
        @(negedge clk);
        href = 1'b1;
        d = next_byte;
        hi = next_byte;
        next_byte = next_byte + 8'h22;
        @(negedge clk);
        d = next_byte;
        exp_q.push_back({hi, next_byte, 11'd1, 11'd1});
        next_byte = next_byte + 8'h22;
        @(negedge clk);
        d = next_byte;
        next_byte = next_byte + 8'h22;
        @(negedge clk);
        d = next_byte;
        next_byte = next_byte + 8'h22;
        @(negedge clk);
        sys_rst = 1'b1;
        href = 1'b0;
        d = 8'd0;
        @(negedge clk);
        sys_rst = 1'b0;
        check("reset_midline", {22'd0, frame_data, frame_en, hcnt, vcnt, frame_new, line_err, frame_short},
              64'd0);
        send_line(8, 1'b0, 0);
        settle("post_reset_idle");
        send_frame(3, 8, 1'b0);
        send_frame(3, 8, 1'b0);
        send_frame(3, 8, 1'b1);
        settle("post_reset_capture");
        check("hold_after_reset", {26'd0, frame_data, hcnt, vcnt}, {26'd0, 16'hFE20, 11'd4, 11'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mt9d111_capture.md
Name: mt9d111_capture

Overview:
- Front-end capture stage in the MT9D111 clock domain.
- Converts the sensor's 8-bit DVP stream (VSYNC/HREF/D[7:0]) into RGB565 pixels with frame, line and pixel strobes and counters.
- Its outputs drive the camera-to-DDR write path directly: FrameData, FrameDataEn, FrameHCnt, FrameVCnt and FrameNewEn.
- Also skips sensor start-up frames, clips to the configured frame size and flags malformed lines.

Parameters:
H_WIDTH, 800, active pixels per line kept; pixels beyond this are dropped.
V_WIDTH, 600, active lines per frame kept; lines beyond this are dropped.
SKIP_FRAMES, 2, complete frames discarded after reset before output starts (0..15).

Ports:
MT9D111_CLK  in  1  sensor pixel clock; sole clock, rising edge.
sys_rst  in  1  synchronous reset, active-high.
MT9D111_VSYNC  in  1  high during vertical blanking.
MT9D111_HREF  in  1  high while line bytes are valid.
MT9D111_D  in  8  sensor data byte.
MT9D111_FrameData  out  16  RGB565 pixel, valid with FrameDataEn.
MT9D111_FrameDataEn  out  1  one-cycle pixel strobe.
MT9D111_FrameHCnt  out  11  1-based pixel index within line (1..H_WIDTH), valid with FrameDataEn.
MT9D111_FrameVCnt  out  11  0-based line index (0..V_WIDTH-1), valid with FrameDataEn.
MT9D111_FrameNewEn  out  1  one-cycle pulse at start of each output frame.
line_err  out  1  one-cycle pulse: line ended on an odd byte count.
frame_short  out  1  one-cycle pulse: frame ended with fewer than V_WIDTH lines.

Behaviour:
- Reset values:
  - All outputs 0.
  - State WAIT_VS; skip counter = SKIP_FRAMES.
  - Byte phase 0; internal H/V counters 0.
- Input stage:
  - VSYNC, HREF and D are registered once (_r), then VSYNC and HREF once more (_rr).
  - Edges are detected on _r vs _rr.
- States:
  - WAIT_VS: wait for VSYNC_r high (blanking seen) -> SYNC. Guarantees no partial frame after reset or a mid-frame reset.
  - SYNC: on VSYNC falling edge:
    - skip counter != 0 -> SKIP and decrement the counter.
    - otherwise -> ACTIVE; pulse FrameNewEn in the same cycle the state changes; clear V counter.
  - SKIP: all bytes ignored; on VSYNC rising edge -> SYNC.
  - ACTIVE: capture as below; on VSYNC rising edge -> SYNC.
    - If the V counter < V_WIDTH at this point, pulse frame_short.
- Pixel assembly (ACTIVE, HREF_r high):
  - Phase 0 latches D_r as byte[15:8].
  - Phase 1 forms {hi, D_r}.
  - The phase toggles every HREF_r-high cycle.
- Pixel output:
  - On each phase-1 cycle, if H counter < H_WIDTH and V counter < V_WIDTH, the next cycle drives FrameDataEn=1, FrameData, FrameHCnt=H+1, FrameVCnt=V. Then H increments.
  - Latency: 2 cycles from the second byte at the pins to FrameDataEn.
  - Pixels with H >= H_WIDTH, or lines with V >= V_WIDTH, produce no strobe. Counting continues, saturating at 2047.
- HREF falling edge:
  - If phase = 1 (odd byte count): pulse line_err and discard the partial byte.
  - If at least one byte was seen in the line: V increments (saturating at 2047).
  - H and phase are cleared.
- FrameData and FrameHCnt/FrameVCnt hold their last values when FrameDataEn is 0.
- VSYNC rising while HREF_r is high: the line is treated as ended exactly as on an HREF fall (same line_err check), then the frame ends.
- sys_rst in any state: immediate return to the reset values the next cycle. Any in-flight FrameDataEn is cancelled.

Optional Feature:
- Macro: MT9D111_CAPTURE_TESTPAT_EN.
- Defined:
  - Adds input port tp_sel (1 bit, sampled each cycle).
  - When tp_sel=1, FrameData is replaced by colour bars selected by FrameHCnt-1 in four equal quarters of H_WIDTH: red 16'hF800, green 16'h07E0, blue 16'h001F, magenta 16'hF81F.
  - Strobe timing is unchanged.
- Undefined: no tp_sel port; FrameData is always sensor data.

Test Plan:
- Reset, SKIP_FRAMES=2, three 4x3 frames of bytes 0x12,0x34,... -> no FrameDataEn during frames 1-2; frame 3 gives FrameNewEn once, then 12 strobes, first FrameData=16'h1234 with HCnt=1/VCnt=0, last HCnt=4/VCnt=2.
- SKIP_FRAMES=0, line of 9 bytes -> 4 pixel strobes, line_err pulses once at the HREF fall, next line VCnt=1.
- H_WIDTH=4, V_WIDTH=2, sensor sends 6 px x 3 lines -> exactly 8 strobes, HCnt never >4, VCnt never >1, frame_short=0.
- V_WIDTH=3, frame of 2 lines -> frame_short pulses at the VSYNC rise; next frame restarts at VCnt=0.
- Assert sys_rst mid-line of frame 3 -> outputs 0 next cycle; no strobes until a VSYNC high-then-fall, then FrameNewEn and clean capture.
- With MT9D111_CAPTURE_TESTPAT_EN, H_WIDTH=8, tp_sel=1 -> FrameData sequence F800,F800,07E0,07E0,001F,001F,F81F,F81F per line.
